chip_checker_led_pio: RTL and testbench

Parametrised Avalon-MM output PIO that drives the board LED bank from the Nios II system, replacing the fixed 14-bit single-register LED port. Provides atomic bit set/clear registers and a per-bit hardware blink mode with a programmable half-period timer, so firmware can flag chip-test pass, fail or busy without polling loops. Sits on the system interconnect as a zero-wait-state slave. `out_port` connects directly to the LED pins.

---
 rtl/chip_checker_pio_pkg.sv | 13 +
 rtl/chip_checker_led_pio_if.sv | 22 ++
 rtl/chip_checker_pio_blink_timer.sv | 33 +++
 rtl/chip_checker_led_pio.sv | 71 +++++++
 tb/tb_chip_checker_led_pio.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_checker_pio_pkg.sv
// Shared constants for the LED PIO: register word addresses and STATUS bit layout.
package chip_checker_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_MASK   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/chip_checker_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
interface chip_checker_led_pio_if;

    // Write is taken on any rising clk edge with chipselect high and write_n low;
    // there is no waitrequest. readdata is a combinational decode of address.
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/chip_checker_pio_blink_timer.sv
// Square-wave phase generator: phase spends `period` cycles high, then `period` low.
module chip_checker_pio_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;

    // A zero period parks the timer with phase high so masked bits show data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (restart || (period == '0)) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == (period - 1'b1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/chip_checker_led_pio.sv
// LED output PIO with atomic set/clear, per-bit blink mask and programmable blink period.
module chip_checker_led_pio
    import chip_checker_pio_pkg::*;
#(
    parameter int               WIDTH       = 14,
    parameter int               PERIOD_W    = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    chip_checker_led_pio_if.slave   bus,
    output logic [WIDTH-1:0]        out_port
);

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [PERIOD_W-1:0] r_period;

    logic                w_wr;
    logic [WIDTH-1:0]    w_wdata;
    logic                w_restart;
    logic                w_phase;
    logic [31:0]         w_readdata;

    assign w_wr      = bus.chipselect && !bus.write_n;
    assign w_wdata   = bus.writedata[WIDTH-1:0];
    assign w_restart = w_wr && (bus.address == ADDR_PERIOD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= RESET_VALUE;
            r_mask   <= '0;
            r_period <= '0;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA:   r_data   <= w_wdata;
                ADDR_SET:    r_data   <= r_data | w_wdata;
                ADDR_CLEAR:  r_data   <= r_data & ~w_wdata;
                ADDR_MASK:   r_mask   <= w_wdata;
                ADDR_PERIOD: r_period <= bus.writedata[PERIOD_W-1:0];
                default:     ;
            endcase
        end
    end

    chip_checker_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (r_period),
        .restart (w_restart),
        .phase   (w_phase)
    );

    // SET/CLEAR and the unused slots read as zero; reads never alter state.
    always_comb begin
        w_readdata = '0;
        case (bus.address)
            ADDR_DATA:   w_readdata[WIDTH-1:0]    = r_data;
            ADDR_MASK:   w_readdata[WIDTH-1:0]    = r_mask;
            ADDR_PERIOD: w_readdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: w_readdata[STATUS_PHASE_BIT] = w_phase;
            default:     w_readdata = '0;
        endcase
    end

    assign bus.readdata = w_readdata;
    assign out_port     = r_data & ~(r_mask & {WIDTH{~w_phase}});

endmodule

// File: tb/tb_chip_checker_led_pio.sv
// Self-checking bench for chip_checker_led_pio: vector table, hand corner cases, random vs model.
module tb_chip_checker_led_pio;
    import chip_checker_pio_pkg::*;

    localparam int               W  = 14;
    localparam int               PW = 24;
    localparam logic [W-1:0]     RV = 14'h0005;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    chip_checker_led_pio_if bus_a ();
    chip_checker_led_pio_if bus_b ();
    logic [W-1:0]  out_a;
    logic [31:0]   out_b;

    chip_checker_led_pio #(.WIDTH(W), .PERIOD_W(PW), .RESET_VALUE(RV)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .out_port(out_a)
    );
    chip_checker_led_pio #(.WIDTH(32), .PERIOD_W(32), .RESET_VALUE(32'h0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .out_port(out_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: register contents plus the cycle at which the blink last restarted.
    logic [W-1:0]  m_data, m_mask;
    logic [PW-1:0] m_period;
    int            m_restart;

    function automatic logic m_phase();
        int k;
        if (m_period == '0) return 1'b1;
        k = cyc - m_restart;
        return ((k / int'(m_period)) % 2) == 0;
    endfunction

    function automatic logic [W-1:0] m_out();
        logic [W-1:0] o;
        o = m_data;
        for (int i = 0; i < W; i++)
            if (m_mask[i] && !m_phase()) o[i] = 1'b0;
        return o;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return 32'(m_mask);
            3'd4:    return 32'(m_period);
            3'd5:    return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = RV; m_mask = '0; m_period = '0; m_restart = cyc;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_data = d[W-1:0];
            3'd1: m_data = m_data | d[W-1:0];
            3'd2: m_data = m_data & ~d[W-1:0];
            3'd3: m_mask = d[W-1:0];
            3'd4: begin m_period = d[PW-1:0]; m_restart = cyc; end
            default: ;
        endcase
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
        bus_a.address = a; bus_a.writedata = d;
        bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        @(posedge clk); #1;
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        model_write(a, d);
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
        bus_b.address = a; bus_b.writedata = d;
        bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        @(posedge clk); #1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    task automatic rd_a(input logic [2:0] a, output logic [31:0] d);
        bus_a.address = a; #1; d = bus_a.readdata;
    endtask

    task automatic rd_b(input logic [2:0] a, output logic [31:0] d);
        bus_b.address = a; #1; d = bus_b.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [W-1:0] exp_out;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] rd;

    initial begin
        vecs[0] = '{3'd0, 32'h0000_00F0, 14'h00F0, 3'd0, 32'h0F0};
        vecs[1] = '{3'd1, 32'h0000_0003, 14'h00F3, 3'd1, 32'h000};
        vecs[2] = '{3'd2, 32'h0000_0030, 14'h00C3, 3'd2, 32'h000};
        vecs[3] = '{3'd6, 32'h0000_3FFF, 14'h00C3, 3'd6, 32'h000};
        vecs[4] = '{3'd7, 32'hFFFF_FFFF, 14'h00C3, 3'd0, 32'h0C3};

        reset = 1'b1;
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = '0; bus_a.writedata = '0;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = '0; bus_b.writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset state
        check("reset_out", 32'(out_a), 32'h5);
        rd_a(ADDR_DATA, rd);   check("reset_data", rd, 32'h5);
        rd_a(ADDR_MASK, rd);   check("reset_mask", rd, 32'h0);
        rd_a(ADDR_PERIOD, rd); check("reset_period", rd, 32'h0);
        idle(1);
        rd_a(ADDR_STATUS, rd); check("reset_status", rd, 32'h1);

        // Table: data/set/clear and writes to the unused slots
        for (int i = 0; i < 5; i++) begin
            check($sformatf("vec%0d_pre", i), 32'(out_a), (i == 0) ? 32'h5 : 32'(vecs[i-1].exp_out));
            wr_a(vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
            rd_a(vecs[i].rd_addr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Blink: bit 0 high 4 cycles, low 4 cycles
        wr_a(ADDR_DATA, 32'h3FFF);
        wr_a(ADDR_MASK, 32'h1);
        wr_a(ADDR_PERIOD, 32'd4);
        for (int k = 0; k < 16; k++) begin
            check("blink4_bit0", 32'(out_a[0]), ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check("blink4_upper", 32'(out_a[W-1:1]), 32'h1FFF);
            rd_a(ADDR_STATUS, rd);
            check("blink4_status", rd, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
            idle(1);
        end
        idle(5);
        rd_a(ADDR_STATUS, rd);
        check("midblink_phase0", rd, 32'd0);
        wr_a(ADDR_PERIOD, 32'd2);
        for (int j = 0; j < 6; j++) begin
            rd_a(ADDR_STATUS, rd);
            check("blink2_status", rd, ((j / 2) % 2 == 0) ? 32'd1 : 32'd0);
            check("blink2_out", 32'(out_a), ((j / 2) % 2 == 0) ? 32'h3FFF : 32'h3FFE);
            idle(1);
        end
        idle(1);
        wr_a(ADDR_PERIOD, 32'd0);
        for (int j = 0; j < 5; j++) begin
            check("period0_out", 32'(out_a), 32'h3FFF);
            rd_a(ADDR_STATUS, rd);
            check("period0_status", rd, 32'd1);
            idle(1);
        end

        // Period 1 toggles every cycle
        wr_a(ADDR_PERIOD, 32'd1);
        for (int j = 0; j < 4; j++) begin
            check("period1_bit0", 32'(out_a[0]), (j % 2 == 0) ? 32'd1 : 32'd0);
            idle(1);
        end

        // Reset wins over a simultaneous write, mid-blink
        wr_a(ADDR_PERIOD, 32'd3);
        idle(4);
        bus_a.address = ADDR_SET; bus_a.writedata = 32'hFFF;
        bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        model_reset();
        check("rstwr_out", 32'(out_a), 32'h5);
        rd_a(ADDR_DATA, rd);   check("rstwr_data", rd, 32'h5);
        rd_a(ADDR_MASK, rd);   check("rstwr_mask", rd, 32'h0);
        rd_a(ADDR_PERIOD, rd); check("rstwr_period", rd, 32'h0);
        rd_a(ADDR_STATUS, rd); check("rstwr_status", rd, 32'h1);

        // 32-bit instance (also reset by the pulse above)
        wr_b(ADDR_DATA, 32'hFFFF_FFFF);
        rd_b(ADDR_DATA, rd);   check("w32_data", rd, 32'hFFFF_FFFF);
        check("w32_out", out_b, 32'hFFFF_FFFF);
        wr_b(ADDR_PERIOD, 32'hFFFF_FFFF);
        rd_b(ADDR_PERIOD, rd); check("w32_period", rd, 32'hFFFF_FFFF);
        wr_b(3'd6, 32'h0);
        wr_b(3'd7, 32'h0);
        check("w32_out_after67", out_b, 32'hFFFF_FFFF);
        rd_b(3'd6, rd);        check("w32_rd6", rd, 32'h0);
        rd_b(3'd7, rd);        check("w32_rd7", rd, 32'h0);
        rd_b(ADDR_DATA, rd);   check("w32_data_after67", rd, 32'hFFFF_FFFF);

        // Random traffic against the model
        idle(1);
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 3) != 0) begin
                a = 3'($urandom_range(0, 7));
                d = (a == ADDR_PERIOD) ? 32'($urandom_range(0, 6)) : $urandom;
                wr_a(a, d);
            end else begin
                idle($urandom_range(1, 12));
            end
            check("rand_out", 32'(out_a), 32'(m_out()));
            a = 3'($urandom_range(0, 7));
            rd_a(a, rd);
            check($sformatf("rand_rd%0d", a), rd, m_read(a));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
